// File: rtl/fabric_config_loader_if.sv
// Load-stream and config-write bundle between the image source, the loader and the fabric.
// The master side feeds words in and observes status; the slave side is the loader.
interface fabric_config_loader_if #(
  parameter int unsigned AW = 4
);
  logic          start;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [31:0]   cfg_data;
  logic          fabric_en;
  logic          busy;
  logic          done;
  logic          error;
  logic [1:0]    err_code;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, cfg_we, cfg_addr, cfg_data, fabric_en, busy, done, error, err_code
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, cfg_we, cfg_addr, cfg_data, fabric_en, busy, done, error, err_code
  );
endinterface

// File: rtl/fabric_config_loader.sv
// Streams a framed, checksummed configuration image into the fabric's config registers and
// enables the fabric only after a complete, verified load.
module fabric_config_loader #(
  parameter int unsigned WORDS = 10,
  parameter logic [15:0] SYNC  = 16'hCF60,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input logic clock,
  input logic reset_n,
  fabric_config_loader_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StHdr, StLoad, StChk, StDone, StErr} state_e;

  localparam logic [15:0]   CountVal = 16'(WORDS);
  localparam logic [AW-1:0] LastIdx  = AW'(WORDS - 1);

  state_e        state_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   xsum_q;
  logic          cfg_we_q;
  logic [AW-1:0] cfg_addr_q;
  logic [31:0]   cfg_data_q;
  logic          fabric_en_q;
  logic          done_q;
  logic          error_q;
  logic [1:0]    err_code_q;

  logic active;
  logic accept;

  // Readiness depends on state only, never on in_valid.
  assign active = (state_q == StHdr) || (state_q == StLoad) || (state_q == StChk);
  assign accept = bus.in_valid && active;

  assign bus.in_ready  = active;
  assign bus.busy      = active;
  assign bus.cfg_we    = cfg_we_q;
  assign bus.cfg_addr  = cfg_addr_q;
  assign bus.cfg_data  = cfg_data_q;
  assign bus.fabric_en = fabric_en_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.err_code  = err_code_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      xsum_q      <= '0;
      cfg_we_q    <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      fabric_en_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      cfg_we_q <= 1'b0;
      case (state_q)
        StIdle, StDone, StErr: begin
          if (bus.start) begin
            state_q     <= StHdr;
            idx_q       <= '0;
            xsum_q      <= '0;
            fabric_en_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 2'd0;
          end
        end
        StHdr: begin
          if (accept) begin
            // A bad sync word outranks a bad count.
            if (bus.in_data[31:16] != SYNC) begin
              state_q    <= StErr;
              error_q    <= 1'b1;
              err_code_q <= 2'd1;
            end else if (bus.in_data[15:0] != CountVal) begin
              state_q    <= StErr;
              error_q    <= 1'b1;
              err_code_q <= 2'd2;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        StLoad: begin
          if (accept) begin
            cfg_we_q   <= 1'b1;
            cfg_addr_q <= idx_q;
            cfg_data_q <= bus.in_data;
            xsum_q     <= xsum_q ^ bus.in_data;
            if (idx_q == LastIdx) begin
              state_q <= StChk;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StChk: begin
          if (accept) begin
            if (bus.in_data == xsum_q) begin
              state_q     <= StDone;
              fabric_en_q <= 1'b1;
              done_q      <= 1'b1;
            end else begin
              state_q    <= StErr;
              error_q    <= 1'b1;
              err_code_q <= 2'd3;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench for fabric_config_loader: the driver queues expected config writes as words
// are accepted, a forked monitor pops and compares them whenever cfg_we is seen.
module tb_fabric_config_loader;

  localparam int unsigned WORDS = 10;
  localparam int unsigned AW    = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   start_cyc = 0;
  int   acc_cyc = 0;
  int   exp_idx = 0;
  wr_t  exp_q[$];

  logic [31:0] good[WORDS] = '{32'h0000FF00, 32'h0000FF00, 32'h0000FF00, 32'h0000FF00,
                                32'h0000FF00, 32'h0000FF00, 32'h0000FF00, 32'h0000FF00,
                                32'h00000003, 32'h00000001};

  fabric_config_loader_if #(.AW(AW)) bus ();

  fabric_config_loader #(
    .WORDS (WORDS),
    .SYNC  (16'hCF60),
    .AW    (AW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Entered and left at a rising edge; the word is held until an edge with in_ready high.
  task automatic send_word(input logic [31:0] w, input bit payload, input bit gap,
                           input bit with_start);
    bit   accepted;
    logic rdy;
    accepted = 1'b0;
    #1;
    bus.start = with_start;
    if (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clock);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    for (int n = 0; n < 50 && !accepted; n++) begin
      @(negedge clock);
      rdy = bus.in_ready;
      @(posedge clock);
      if (rdy) accepted = 1'b1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout word=%h", w);
    end else begin
      acc_cyc = cyc;
      if (payload) begin
        exp_q.push_back('{addr: AW'(exp_idx), data: w});
        exp_idx++;
      end
    end
  endtask

  task automatic do_start();
    #1;
    bus.start = 1'b1;
    @(posedge clock);
    start_cyc = cyc;
    exp_idx   = 0;
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] cks, input bit gap);
    send_word(hdr, 1'b0, gap, 1'b0);
    for (int i = 0; i < WORDS; i++) send_word(good[i], 1'b1, gap, 1'b0);
    send_word(cks, 1'b0, gap, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      #1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      @(posedge clock);
    end
  endtask

  task automatic check_status(input string tag, input logic dn, input logic fe, input logic er,
                              input logic [1:0] code, input logic rdy);
    chk({tag, "_done"}, 32'(bus.done), 32'(dn));
    chk({tag, "_fabric_en"}, 32'(bus.fabric_en), 32'(fe));
    chk({tag, "_error"}, 32'(bus.error), 32'(er));
    chk({tag, "_err_code"}, 32'(bus.err_code), 32'(code));
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(rdy));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_cfg_we"}, 32'(bus.cfg_we), 32'd0);
    chk({tag, "_cfg_addr"}, 32'(bus.cfg_addr), 32'd0);
    chk({tag, "_cfg_data"}, bus.cfg_data, 32'd0);
    chk({tag, "_fabric_en"}, 32'(bus.fabric_en), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_error"}, 32'(bus.error), 32'd0);
    chk({tag, "_err_code"}, 32'(bus.err_code), 32'd0);
  endtask

  initial begin
    int w0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    fork
      forever begin
        wr_t e;
        @(negedge clock);
        if (reset_n && bus.cfg_we) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cfg_write_unexpected actual=%0d:%h required=none",
                     bus.cfg_addr, bus.cfg_data);
          end else begin
            e = exp_q.pop_front();
            chk("cfg_addr", 32'(bus.cfg_addr), 32'(e.addr));
            chk("cfg_data", bus.cfg_data, e.data);
          end
        end
      end
    join_none

    #3;
    check_all_zero("reset");
    #10;
    reset_n = 1'b1;
    @(posedge clock);

    // Good load, in_valid held high: header at edge 1, checksum at edge 12 after start.
    w0 = wr_cnt;
    do_start();
    send_frame(32'hCF60000A, 32'h00000002, 1'b0);
    #1;
    chk("good_cycles", 32'(acc_cyc - start_cyc + 1), 32'd13);
    check_status("good", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    bus.in_data = 32'hBAD0BAD0;
    idle(2);
    chk("good_writes", 32'(wr_cnt - w0), 32'd10);
    chk("good_q_empty", 32'(exp_q.size()), 32'd0);

    // Words offered while idle must not be consumed.
    #1;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
    chk("idle_done_hold", 32'(bus.done), 32'd1);
    idle(1);

    // Bad sync.
    w0 = wr_cnt;
    do_start();
    #1;
    chk("start_clears_fabric_en", 32'(bus.fabric_en), 32'd0);
    chk("start_busy", 32'(bus.busy), 32'd1);
    send_word(32'hDEAD000A, 1'b0, 1'b0, 1'b0);
    #1;
    check_status("badsync", 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
    idle(3);
    chk("badsync_writes", 32'(wr_cnt - w0), 32'd0);
    chk("badsync_err_hold", 32'(bus.err_code), 32'd1);

    // Bad count, then both wrong (sync wins).
    do_start();
    send_word(32'hCF600009, 1'b0, 1'b0, 1'b0);
    #1;
    check_status("badcount", 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    idle(1);
    do_start();
    send_word(32'hDEAD0009, 1'b0, 1'b0, 1'b0);
    #1;
    chk("bothbad_err_code", 32'(bus.err_code), 32'd1);
    idle(1);

    // Bad checksum: writes still happen, fabric stays disabled.
    w0 = wr_cnt;
    do_start();
    send_frame(32'hCF60000A, 32'h00000000, 1'b0);
    #1;
    check_status("badcks", 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
    idle(2);
    chk("badcks_writes", 32'(wr_cnt - w0), 32'd10);

    // Backpressure: one idle cycle before each of the 12 words -> checksum at edge 24.
    w0 = wr_cnt;
    do_start();
    send_frame(32'hCF60000A, 32'h00000002, 1'b1);
    #1;
    chk("bp_cycles", 32'(acc_cyc - start_cyc + 1), 32'd25);
    check_status("bp", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    idle(2);
    chk("bp_writes", 32'(wr_cnt - w0), 32'd10);

    // Reset after four payload writes.
    w0 = wr_cnt;
    do_start();
    send_word(32'hCF60000A, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_word(good[i], 1'b1, 1'b0, 1'b0);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    chk("midreset_writes", 32'(wr_cnt - w0), 32'd4);
    exp_q.delete();
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    w0 = wr_cnt;
    do_start();
    send_frame(32'hCF60000A, 32'h00000002, 1'b0);
    #1;
    check_status("reload", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    idle(2);
    chk("reload_writes", 32'(wr_cnt - w0), 32'd10);

    // Start while busy is ignored; the frame completes normally.
    w0 = wr_cnt;
    do_start();
    send_word(32'hCF60000A, 1'b0, 1'b0, 1'b0);
    send_word(good[0], 1'b1, 1'b0, 1'b0);
    send_word(good[1], 1'b1, 1'b0, 1'b1);
    for (int i = 2; i < WORDS; i++) send_word(good[i], 1'b1, 1'b0, 1'b0);
    send_word(32'h00000002, 1'b0, 1'b0, 1'b0);
    #1;
    check_status("restart", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    idle(2);
    chk("restart_writes", 32'(wr_cnt - w0), 32'd10);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
